wormhole_arbiter8: RTL

Clocked 8-input round-robin wormhole arbiter for the router output stage. Eight four-phase req/ack input channels A–H compete for one four-phase output channel. Once a channel wins, the grant is locked to it until a tail flit passes; only then does round-robin arbitration resume. Flit data is captured into an output register and forwarded unmodified.

---
 rtl/wormhole_arbiter8_if.sv | 34 +++
 rtl/wormhole_arbiter8.sv | 104 ++++++++++
 2 files changed

// File: rtl/wormhole_arbiter8_if.sv
// Handshake bundle for the 8-input wormhole arbiter: eight four-phase input
// channels A-H, one four-phase output channel, plus grant/lock status.
`timescale 1ns/1ps
interface wormhole_arbiter8_if #(parameter int data_width = 32);
  logic                  inA_req, inB_req, inC_req, inD_req;
  logic                  inE_req, inF_req, inG_req, inH_req;
  logic [data_width-1:0] inA_data, inB_data, inC_data, inD_data;
  logic [data_width-1:0] inE_data, inF_data, inG_data, inH_data;
  logic                  inA_ack, inB_ack, inC_ack, inD_ack;
  logic                  inE_ack, inF_ack, inG_ack, inH_ack;
  logic                  out_req;
  logic [data_width-1:0] out_data;
  logic                  out_ack;
  logic [2:0]            grant;
  logic                  locked;

  // arbiter side
  modport master (
    input  inA_req, inB_req, inC_req, inD_req, inE_req, inF_req, inG_req, inH_req,
    input  inA_data, inB_data, inC_data, inD_data, inE_data, inF_data, inG_data, inH_data,
    input  out_ack,
    output inA_ack, inB_ack, inC_ack, inD_ack, inE_ack, inF_ack, inG_ack, inH_ack,
    output out_req, out_data, grant, locked
  );

  // environment side (sources and sink)
  modport slave (
    output inA_req, inB_req, inC_req, inD_req, inE_req, inF_req, inG_req, inH_req,
    output inA_data, inB_data, inC_data, inD_data, inE_data, inF_data, inG_data, inH_data,
    output out_ack,
    input  inA_ack, inB_ack, inC_ack, inD_ack, inE_ack, inF_ack, inG_ack, inH_ack,
    input  out_req, out_data, grant, locked
  );
endinterface

// File: rtl/wormhole_arbiter8.sv
// 8-input round-robin wormhole arbiter. A winning channel keeps the output
// until its tail flit (msb=1) completes; then the round-robin pointer moves
// past it. All outputs are registered.
`timescale 1ns/1ps
module wormhole_arbiter8 #(
  parameter int data_width = 32
) (
  input  logic                clk,
  input  logic                rst,
  wormhole_arbiter8_if.master bus
);

  typedef enum logic [1:0] {IDLE, SEND, RET} state_t;

  state_t                         state;
  logic [2:0]                     ptr;
  logic [2:0]                     grant_r;
  logic                           locked_r;
  logic                           out_req_r;
  logic [data_width-1:0]          out_data_r;
  logic [7:0]                     ack_r;

  logic [7:0]                     req;
  logic [7:0][data_width-1:0]     din;
  logic                           pick_vld;
  logic [2:0]                     pick_idx;
  logic [2:0]                     cand;

  assign req = {bus.inH_req, bus.inG_req, bus.inF_req, bus.inE_req,
                bus.inD_req, bus.inC_req, bus.inB_req, bus.inA_req};
  assign din = {bus.inH_data, bus.inG_data, bus.inF_data, bus.inE_data,
                bus.inD_data, bus.inC_data, bus.inB_data, bus.inA_data};

  // Pick: the locked channel only, else first request scanning from ptr.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = grant_r;
    cand     = '0;
    if (locked_r) begin
      pick_vld = req[grant_r];
    end else begin
      for (int i = 0; i < 8; i++) begin
        cand = ptr + 3'(i);
        if (!pick_vld && req[cand]) begin
          pick_vld = 1'b1;
          pick_idx = cand;
        end
      end
    end
  end

  // Handshake FSM with registered outputs and lock/pointer bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      grant_r    <= '0;
      locked_r   <= 1'b0;
      out_req_r  <= 1'b0;
      out_data_r <= '0;
      ack_r      <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          out_data_r <= din[pick_idx];
          grant_r    <= pick_idx;
          out_req_r  <= 1'b1;
          state      <= SEND;
        end
        SEND: if (bus.out_ack) begin
          out_req_r       <= 1'b0;
          ack_r[grant_r]  <= 1'b1;
          state           <= RET;
        end
        RET: if (!req[grant_r] && !bus.out_ack) begin
          ack_r <= '0;
          state <= IDLE;
          // tail flit frees the output and moves priority past the winner
          if (out_data_r[data_width-1]) begin
            locked_r <= 1'b0;
            ptr      <= grant_r + 3'd1;
          end else begin
            locked_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_req  = out_req_r;
  assign bus.out_data = out_data_r;
  assign bus.grant    = grant_r;
  assign bus.locked   = locked_r;
  assign bus.inA_ack  = ack_r[0];
  assign bus.inB_ack  = ack_r[1];
  assign bus.inC_ack  = ack_r[2];
  assign bus.inD_ack  = ack_r[3];
  assign bus.inE_ack  = ack_r[4];
  assign bus.inF_ack  = ack_r[5];
  assign bus.inG_ack  = ack_r[6];
  assign bus.inH_ack  = ack_r[7];

endmodule
